// File: rtl/hicore_pkg.sv
// ---------------------------------------------------------------------------
// hicore_pkg
// Types and constants shared by the commit controller and its sub-modules.
// - Default data, PC and index widths.
// - Bit positions of the fields in the writeback info word.
// - Encoding of the commit FSM states.
// - Retire classification, with a helper function that applies the
//   priority order used to classify a retiring entry.
// ---------------------------------------------------------------------------
package hicore_pkg;

  // Default widths
  localparam int DEF_REG_SIZE     = 32;
  localparam int DEF_PC_SIZE      = 32;
  localparam int DEF_RFIDX_WIDTH  = 5;
  localparam int DEF_CSRIDX_WIDTH = 12;
  localparam int DEF_WB_SIZE      = 8;

  // Writeback info field positions. Bit 7 is reserved.
  localparam int EXC_BIT   = 0;
  localparam int REDIR_BIT = 1;
  localparam int CAUSE_LSB = 2;
  localparam int CAUSE_W   = 5;

  // Commit FSM states
  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_FLUSH      = 2'd1,
    ST_FENCE_WAIT = 2'd2
  } commit_state_e;

  // Kind of the entry that is retiring this cycle
  typedef enum logic [2:0] {
    RC_NORMAL   = 3'd0,
    RC_REDIRECT = 3'd1,
    RC_FENCE_I  = 3'd2,
    RC_MRET     = 3'd3,
    RC_EXC      = 3'd4
  } retire_class_e;

  // Priority: exception > mret > fence_i > redirect > normal.
  function automatic retire_class_e classify(input logic exc,
                                             input logic mret,
                                             input logic fence_i,
                                             input logic redir);
    if (exc)          return RC_EXC;
    else if (mret)    return RC_MRET;
    else if (fence_i) return RC_FENCE_I;
    else if (redir)   return RC_REDIRECT;
    else              return RC_NORMAL;
  endfunction

endpackage

// File: rtl/hicore_minstret_cnt.sv
// ---------------------------------------------------------------------------
// hicore_minstret_cnt
// Retired-instruction counter. It wraps from all-ones to zero.
// Ports:
//   clk      - clock
//   rst      - asynchronous active-high reset; clears the count
//   inc_en_i - add one at the next rising clock edge
//   count_o  - current count
// ---------------------------------------------------------------------------
module hicore_minstret_cnt #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // NOTE: set a default value first in every always_comb; otherwise a path
  // that does not assign the variable infers a latch.
  always_comb begin
    count_d = count_q;
    if (inc_en_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hicore_commit_ctrl.sv
// ---------------------------------------------------------------------------
// hicore_commit_ctrl
// In-order retirement sequencer. It sits between the ROB head and the
// architectural state.
//   - Retires the head entry whenever the FSM is in RUN and the entry is
//     written back.
//   - Drives the registered RF and CSR write ports.
//   - Turns exceptions, mret, fence.i and mispredicts into a one-cycle flush
//     plus a fetch redirect.
//   - Counts retired instructions in minstret.
// Ports:
//   clk, rst                - clock, asynchronous active-high reset
//   commit_ready/valid      - ROB head handshake; the head pops on valid&ready
//   commit_rd_* / csr_*     - destination register and CSR of the head entry
//   commit_fence_i_op, commit_mret_op, commit_next_pc, commit_info
//                           - classification inputs for the head entry
//   rf_* / csr_*            - write ports, one-cycle pulses
//   trap_*, mret_req        - trap entry and trap return requests to CSR unit
//   csr_mtvec, csr_mepc     - trap vector and return PC
//   icache_inv_req/done     - instruction-cache invalidate handshake
//   flush, redirect_*       - pipeline flush and fetch redirect
//   minstret                - 64-bit retired-instruction counter
// ---------------------------------------------------------------------------
module hicore_commit_ctrl
  import hicore_pkg::*;
#(
  parameter int REG_SIZE     = DEF_REG_SIZE,
  parameter int PC_SIZE      = DEF_PC_SIZE,
  parameter int RFIDX_WIDTH  = DEF_RFIDX_WIDTH,
  parameter int CSRIDX_WIDTH = DEF_CSRIDX_WIDTH,
  parameter int WB_SIZE      = DEF_WB_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    commit_ready,
  output logic                    commit_valid,
  input  logic                    commit_rd_need,
  input  logic [RFIDX_WIDTH-1:0]  commit_rd_idx,
  input  logic [REG_SIZE-1:0]     commit_rd_data,
  input  logic                    commit_csr_need,
  input  logic [CSRIDX_WIDTH-1:0] commit_csr_idx,
  input  logic [REG_SIZE-1:0]     commit_csr_data,
  input  logic                    commit_fence_i_op,
  input  logic                    commit_mret_op,
  input  logic [PC_SIZE-1:0]      commit_next_pc,
  input  logic [WB_SIZE-1:0]      commit_info,
  output logic                    rf_wen,
  output logic [RFIDX_WIDTH-1:0]  rf_widx,
  output logic [REG_SIZE-1:0]     rf_wdata,
  output logic                    csr_wen,
  output logic [CSRIDX_WIDTH-1:0] csr_widx,
  output logic [REG_SIZE-1:0]     csr_wdata,
  output logic                    trap_req,
  output logic [4:0]              trap_cause,
  output logic [PC_SIZE-1:0]      trap_epc,
  output logic                    mret_req,
  input  logic [PC_SIZE-1:0]      csr_mtvec,
  input  logic [PC_SIZE-1:0]      csr_mepc,
  output logic                    icache_inv_req,
  input  logic                    icache_inv_done,
  output logic                    flush,
  output logic                    redirect_valid,
  output logic [PC_SIZE-1:0]      redirect_pc,
  output logic [63:0]             minstret
);

  commit_state_e             state_q;
  logic                      rf_wen_q;
  logic [RFIDX_WIDTH-1:0]    rf_widx_q;
  logic [REG_SIZE-1:0]       rf_wdata_q;
  logic                      csr_wen_q;
  logic [CSRIDX_WIDTH-1:0]   csr_widx_q;
  logic [REG_SIZE-1:0]       csr_wdata_q;
  logic                      trap_req_q;
  logic [4:0]                trap_cause_q;
  logic [PC_SIZE-1:0]        trap_epc_q;
  logic                      mret_req_q;
  logic                      inv_req_q;
  logic                      flush_q;
  logic                      redirect_valid_q;
  logic [PC_SIZE-1:0]        redirect_pc_q;
  logic [PC_SIZE-1:0]        fence_pc_q;  // next_pc of the fence.i, used after invalidate

  logic          retire;
  retire_class_e rclass;
  logic          rd_wen;
  logic          unused_info;

  // Only RUN accepts the head entry. commit_ready has no effect in the other
  // states.
  assign commit_valid = (state_q == ST_RUN) & commit_ready;
  assign retire       = commit_valid & commit_ready;
  assign rclass       = classify(commit_info[EXC_BIT], commit_mret_op,
                                 commit_fence_i_op, commit_info[REDIR_BIT]);
  assign rd_wen       = commit_rd_need & (commit_rd_idx != '0);  // x0 is never written
  assign unused_info  = ^commit_info;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_RUN;
      rf_wen_q         <= 1'b0;
      rf_widx_q        <= '0;
      rf_wdata_q       <= '0;
      csr_wen_q        <= 1'b0;
      csr_widx_q       <= '0;
      csr_wdata_q      <= '0;
      trap_req_q       <= 1'b0;
      trap_cause_q     <= '0;
      trap_epc_q       <= '0;
      mret_req_q       <= 1'b0;
      inv_req_q        <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      fence_pc_q       <= '0;
    end else begin
      // Pulse outputs default low, so each one stays high for one cycle only.
      rf_wen_q         <= 1'b0;
      csr_wen_q        <= 1'b0;
      trap_req_q       <= 1'b0;
      mret_req_q       <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;

      unique case (state_q)
        ST_RUN: begin
          if (retire) begin
            rf_widx_q   <= commit_rd_idx;
            rf_wdata_q  <= commit_rd_data;
            csr_widx_q  <= commit_csr_idx;
            csr_wdata_q <= commit_csr_data;
            if (rclass == RC_EXC) begin
              // A faulting entry writes no architectural state.
              trap_req_q       <= 1'b1;
              trap_cause_q     <= commit_info[CAUSE_LSB +: CAUSE_W];
              trap_epc_q       <= commit_next_pc;
              flush_q          <= 1'b1;
              redirect_valid_q <= 1'b1;
              redirect_pc_q    <= csr_mtvec;
              state_q          <= ST_FLUSH;
            end else begin
              rf_wen_q  <= rd_wen;
              csr_wen_q <= commit_csr_need;
              unique case (rclass)
                RC_MRET: begin
                  mret_req_q       <= 1'b1;
                  flush_q          <= 1'b1;
                  redirect_valid_q <= 1'b1;
                  redirect_pc_q    <= csr_mepc;
                  state_q          <= ST_FLUSH;
                end
                RC_FENCE_I: begin
                  inv_req_q  <= 1'b1;
                  fence_pc_q <= commit_next_pc;
                  state_q    <= ST_FENCE_WAIT;
                end
                RC_REDIRECT: begin
                  flush_q          <= 1'b1;
                  redirect_valid_q <= 1'b1;
                  redirect_pc_q    <= commit_next_pc;
                  state_q          <= ST_FLUSH;
                end
                default: ;
              endcase
            end
          end
        end
        ST_FENCE_WAIT: begin
          if (icache_inv_done) begin
            inv_req_q        <= 1'b0;
            flush_q          <= 1'b1;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= fence_pc_q;
            state_q          <= ST_FLUSH;
          end
        end
        ST_FLUSH: state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  hicore_minstret_cnt #(.WIDTH(64)) u_minstret (
    .clk      (clk),
    .rst      (rst),
    .inc_en_i (retire & (rclass != RC_EXC)),
    .count_o  (minstret)
  );

  assign rf_wen         = rf_wen_q;
  assign rf_widx        = rf_widx_q;
  assign rf_wdata       = rf_wdata_q;
  assign csr_wen        = csr_wen_q;
  assign csr_widx       = csr_widx_q;
  assign csr_wdata      = csr_wdata_q;
  assign trap_req       = trap_req_q;
  assign trap_cause     = trap_cause_q;
  assign trap_epc       = trap_epc_q;
  assign mret_req       = mret_req_q;
  assign icache_inv_req = inv_req_q;
  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_hicore_commit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hicore_commit_ctrl
// Directed bench for the commit controller. Inputs change 1 ns after each
// rising edge. Registered outputs are checked at that point. commit_valid is
// combinational, so it is checked 1 ns after the inputs change.
// ---------------------------------------------------------------------------
module tb_hicore_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_ready;
  logic        commit_valid;
  logic        commit_rd_need;
  logic [4:0]  commit_rd_idx;
  logic [31:0] commit_rd_data;
  logic        commit_csr_need;
  logic [11:0] commit_csr_idx;
  logic [31:0] commit_csr_data;
  logic        commit_fence_i_op;
  logic        commit_mret_op;
  logic [31:0] commit_next_pc;
  logic [7:0]  commit_info;
  logic        rf_wen;
  logic [4:0]  rf_widx;
  logic [31:0] rf_wdata;
  logic        csr_wen;
  logic [11:0] csr_widx;
  logic [31:0] csr_wdata;
  logic        trap_req;
  logic [4:0]  trap_cause;
  logic [31:0] trap_epc;
  logic        mret_req;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        icache_inv_req;
  logic        icache_inv_done;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [63:0] minstret;

  int n_cmp  = 0;
  int n_fail = 0;

  hicore_commit_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .commit_ready      (commit_ready),
    .commit_valid      (commit_valid),
    .commit_rd_need    (commit_rd_need),
    .commit_rd_idx     (commit_rd_idx),
    .commit_rd_data    (commit_rd_data),
    .commit_csr_need   (commit_csr_need),
    .commit_csr_idx    (commit_csr_idx),
    .commit_csr_data   (commit_csr_data),
    .commit_fence_i_op (commit_fence_i_op),
    .commit_mret_op    (commit_mret_op),
    .commit_next_pc    (commit_next_pc),
    .commit_info       (commit_info),
    .rf_wen            (rf_wen),
    .rf_widx           (rf_widx),
    .rf_wdata          (rf_wdata),
    .csr_wen           (csr_wen),
    .csr_widx          (csr_widx),
    .csr_wdata         (csr_wdata),
    .trap_req          (trap_req),
    .trap_cause        (trap_cause),
    .trap_epc          (trap_epc),
    .mret_req          (mret_req),
    .csr_mtvec         (csr_mtvec),
    .csr_mepc          (csr_mepc),
    .icache_inv_req    (icache_inv_req),
    .icache_inv_done   (icache_inv_done),
    .flush             (flush),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .minstret          (minstret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a plain head entry. The caller sets any extra flags afterwards.
  task automatic entry(input logic ready, input logic rd_need, input logic [4:0] rd_idx,
                       input logic [31:0] rd_data, input logic [31:0] next_pc);
    commit_ready      = ready;
    commit_rd_need    = rd_need;
    commit_rd_idx     = rd_idx;
    commit_rd_data    = rd_data;
    commit_csr_need   = 1'b0;
    commit_csr_idx    = '0;
    commit_csr_data   = '0;
    commit_fence_i_op = 1'b0;
    commit_mret_op    = 1'b0;
    commit_next_pc    = next_pc;
    commit_info       = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    csr_mtvec       = 32'h100;
    csr_mepc        = 32'h2000;
    icache_inv_done = 1'b0;
    entry(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    tick();

    // Reset state
    check("rst_minstret", minstret, 64'd0);
    check("rst_flush", flush, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_trap_epc", trap_epc, 0);
    check("rst_rf_wen", rf_wen, 0);
    check("rst_inv_req", icache_inv_req, 0);
    rst = 1'b0;

    // Three back-to-back normal retires. The write to x0 is suppressed.
    entry(1'b1, 1'b1, 5'd5, 32'h11, 32'h1004);
    #1 check("n1_commit_valid", commit_valid, 1);
    tick();
    check("n1_rf_wen", rf_wen, 1);
    check("n1_rf_widx", rf_widx, 5);
    check("n1_rf_wdata", rf_wdata, 32'h11);
    check("n1_minstret", minstret, 1);
    entry(1'b1, 1'b1, 5'd6, 32'h22, 32'h1008);
    #1 check("n2_commit_valid", commit_valid, 1);
    tick();
    check("n2_rf_wen", rf_wen, 1);
    check("n2_rf_widx", rf_widx, 6);
    check("n2_rf_wdata", rf_wdata, 32'h22);
    entry(1'b1, 1'b1, 5'd0, 32'h33, 32'h100c);
    #1 check("n3_commit_valid", commit_valid, 1);
    tick();
    check("n3_rf_wen_x0", rf_wen, 0);
    check("n3_minstret", minstret, 3);

    // CSR write
    entry(1'b1, 1'b0, 5'd0, 32'h0, 32'h1010);
    commit_csr_need = 1'b1;
    commit_csr_idx  = 12'h300;
    commit_csr_data = 32'hA5;
    tick();
    check("csr_wen", csr_wen, 1);
    check("csr_widx", csr_widx, 12'h300);
    check("csr_wdata", csr_wdata, 32'hA5);
    check("csr_no_flush", flush, 0);
    check("csr_minstret", minstret, 4);
    entry(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    check("csr_wen_pulse", csr_wen, 0);

    // Exception (cause 3). The rd write must not happen.
    entry(1'b1, 1'b1, 5'd7, 32'h77, 32'h80000010);
    commit_info = 8'h0D;
    tick();
    check("exc_trap_req", trap_req, 1);
    check("exc_trap_cause", trap_cause, 3);
    check("exc_trap_epc", trap_epc, 32'h80000010);
    check("exc_flush", flush, 1);
    check("exc_redirect_valid", redirect_valid, 1);
    check("exc_redirect_pc", redirect_pc, 32'h100);
    check("exc_rf_wen", rf_wen, 0);
    check("exc_minstret", minstret, 4);
    entry(1'b1, 1'b1, 5'd8, 32'h44, 32'h104);
    #1 check("exc_bubble_valid", commit_valid, 0);
    tick();
    check("exc_bubble_rf_wen", rf_wen, 0);
    check("exc_flush_pulse", flush, 0);
    check("exc_trap_pulse", trap_req, 0);
    #1 check("exc_resume_valid", commit_valid, 1);
    tick();
    check("exc_resume_rf_wen", rf_wen, 1);
    check("exc_resume_rf_widx", rf_widx, 8);
    check("exc_resume_minstret", minstret, 5);

    // mret
    entry(1'b1, 1'b0, 5'd0, 32'h0, 32'h108);
    commit_mret_op = 1'b1;
    tick();
    check("mret_req", mret_req, 1);
    check("mret_flush", flush, 1);
    check("mret_redirect_pc", redirect_pc, 32'h2000);
    check("mret_minstret", minstret, 6);
    entry(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    check("mret_req_pulse", mret_req, 0);

    // A done pulse in RUN is ignored.
    icache_inv_done = 1'b1;
    tick();
    icache_inv_done = 1'b0;
    check("stray_done_flush", flush, 0);
    check("stray_done_redirect", redirect_valid, 0);

    // fence.i. The invalidate completes 5 cycles after the request rises.
    entry(1'b1, 1'b1, 5'd9, 32'h99, 32'h3000);
    commit_fence_i_op = 1'b1;
    tick();
    check("fence_inv_req_c1", icache_inv_req, 1);
    check("fence_rf_wen", rf_wen, 1);
    check("fence_rf_widx", rf_widx, 9);
    check("fence_minstret", minstret, 7);
    check("fence_no_flush", flush, 0);
    entry(1'b1, 1'b1, 5'd11, 32'hBB, 32'h3004);
    for (int i = 0; i < 4; i++) begin
      #1 check("fence_wait_valid", commit_valid, 0);
      tick();
      check("fence_inv_req_hold", icache_inv_req, 1);
      check("fence_wait_flush", flush, 0);
    end
    icache_inv_done = 1'b1;
    #1 check("fence_done_valid", commit_valid, 0);
    tick();
    icache_inv_done = 1'b0;
    check("fence_flush", flush, 1);
    check("fence_redirect_valid", redirect_valid, 1);
    check("fence_redirect_pc", redirect_pc, 32'h3000);
    check("fence_inv_req_drop", icache_inv_req, 0);
    check("fence_wait_minstret", minstret, 7);
    commit_ready = 1'b0;
    #1 check("fence_bubble_valid", commit_valid, 0);
    tick();
    check("fence_bubble_rf_wen", rf_wen, 0);

    // Reset asserted during FENCE_WAIT
    entry(1'b1, 1'b0, 5'd0, 32'h0, 32'h4000);
    commit_fence_i_op = 1'b1;
    tick();
    entry(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    check("rfw_inv_req", icache_inv_req, 1);
    tick();
    check("rfw_inv_req_hold", icache_inv_req, 1);
    rst = 1'b1;
    #1;
    check("rfw_rst_inv_req", icache_inv_req, 0);
    check("rfw_rst_minstret", minstret, 64'd0);
    check("rfw_rst_redirect_pc", redirect_pc, 0);
    check("rfw_rst_trap_epc", trap_epc, 0);
    check("rfw_rst_rf_wdata", rf_wdata, 0);
    tick();
    rst = 1'b0;
    entry(1'b1, 1'b1, 5'd10, 32'h55, 32'h5000);
    #1 check("rfw_after_valid", commit_valid, 1);
    tick();
    check("rfw_after_rf_wen", rf_wen, 1);
    check("rfw_after_rf_widx", rf_widx, 10);
    check("rfw_after_rf_wdata", rf_wdata, 32'h55);
    check("rfw_after_minstret", minstret, 1);
    check("rfw_after_inv_req", icache_inv_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
